// File: rtl/cdb_arbiter.sv
// cdb_arbiter: shares the two CDB broadcast lanes between NUM_REQ completion requesters.
//
// Up to two valid requesters are granted per cycle, scanning circularly from rr_ptr.
// The first grant goes to lane 0 and the second to lane 1. Granted results are
// registered onto the CDB one cycle later.
//
// Ports:
//   clock              system clock, rising edge
//   reset              synchronous active-low reset
//   squash             ROB flush; blocks all grants this cycle
//   req_valid          per-requester completed-result flag
//   req_rob_idx        per-requester ROB tag (slice i)
//   req_value          per-requester result (slice i)
//   req_ready          combinational grant; a transfer happens on req_valid & req_ready
//   cdb_valid          registered lane valid
//   cdb_rob_idx        registered lane tag (slice = lane)
//   cdb_value          registered lane result (slice = lane)
//   perf_conflict_cnt  (only with CDB_ARB_PERF_EN) saturating count of cycles where
//                      valid requesters outnumber grants; squash cycles are not counted
//
// Optional feature macro: CDB_ARB_PERF_EN

module cdb_arbiter #(
    parameter int unsigned NUM_REQ   = 6,
    parameter int unsigned NUM_CDB   = 2,
    parameter int unsigned ROB_IDX_W = 5,
    parameter int unsigned XLEN      = 32
) (
    input  logic                           clock,
    input  logic                           reset,
    input  logic                           squash,
    input  logic [NUM_REQ-1:0]             req_valid,
    input  logic [NUM_REQ*ROB_IDX_W-1:0]   req_rob_idx,
    input  logic [NUM_REQ*XLEN-1:0]        req_value,
    output logic [NUM_REQ-1:0]             req_ready,
    output logic [NUM_CDB-1:0]             cdb_valid,
    output logic [NUM_CDB*ROB_IDX_W-1:0]   cdb_rob_idx,
    output logic [NUM_CDB*XLEN-1:0]        cdb_value
`ifdef CDB_ARB_PERF_EN
    ,
    output logic [31:0]                    perf_conflict_cnt
`endif
);

    localparam int unsigned PTR_W = $clog2(NUM_REQ);
    localparam logic [PTR_W-1:0] LAST_REQ = PTR_W'(NUM_REQ - 1);

    logic [PTR_W-1:0]           rr_ptr_q, rr_ptr_d;
    logic [NUM_REQ-1:0]         grant;
    logic [PTR_W-1:0]           sel0, sel1, last_sel;
    logic [1:0]                 n_grant;
    logic [NUM_CDB-1:0]         cdb_valid_q;
    logic [NUM_CDB*ROB_IDX_W-1:0] cdb_rob_idx_q;
    logic [NUM_CDB*XLEN-1:0]    cdb_value_q;

    // Circular scan from rr_ptr; the index is wrapped by subtraction so NUM_REQ
    // need not be a power of two.
    always_comb begin
        int unsigned idx;
        grant    = '0;
        sel0     = '0;
        sel1     = '0;
        last_sel = rr_ptr_q;
        n_grant  = 2'd0;
        idx      = 0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            idx = int'(rr_ptr_q) + k;
            if (idx >= NUM_REQ) begin
                idx = idx - NUM_REQ;
            end
            if (req_valid[idx] && (n_grant < 2'd2)) begin
                if (n_grant == 2'd0) begin
                    sel0 = PTR_W'(idx);
                end else begin
                    sel1 = PTR_W'(idx);
                end
                grant[idx] = 1'b1;
                last_sel   = PTR_W'(idx);
                n_grant    = n_grant + 2'd1;
            end
        end
        // Reset and squash both suppress every grant this cycle.
        if (!reset || squash) begin
            grant   = '0;
            n_grant = 2'd0;
        end
    end

    always_comb begin
        rr_ptr_d = rr_ptr_q;
        if (n_grant != 2'd0) begin
            rr_ptr_d = (last_sel == LAST_REQ) ? '0 : last_sel + PTR_W'(1);
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            rr_ptr_q      <= '0;
            cdb_valid_q   <= '0;
            cdb_rob_idx_q <= '0;
            cdb_value_q   <= '0;
        end else begin
            rr_ptr_q       <= rr_ptr_d;
            cdb_valid_q[0] <= (n_grant != 2'd0);
            cdb_valid_q[1] <= (n_grant == 2'd2);
            // Idle lanes keep their last tag/value.
            if (n_grant != 2'd0) begin
                cdb_rob_idx_q[0 +: ROB_IDX_W] <= req_rob_idx[sel0*ROB_IDX_W +: ROB_IDX_W];
                cdb_value_q[0 +: XLEN]        <= req_value[sel0*XLEN +: XLEN];
            end
            if (n_grant == 2'd2) begin
                cdb_rob_idx_q[ROB_IDX_W +: ROB_IDX_W] <= req_rob_idx[sel1*ROB_IDX_W +: ROB_IDX_W];
                cdb_value_q[XLEN +: XLEN]             <= req_value[sel1*XLEN +: XLEN];
            end
        end
    end

    assign req_ready   = grant;
    assign cdb_valid   = cdb_valid_q;
    assign cdb_rob_idx = cdb_rob_idx_q;
    assign cdb_value   = cdb_value_q;

`ifdef CDB_ARB_PERF_EN
    logic [31:0]  conflict_cnt_q;
    int unsigned  num_valid;
    logic         conflict;

    always_comb begin
        num_valid = 0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            num_valid = num_valid + {31'd0, req_valid[k]};
        end
        conflict = !squash && (num_valid > {30'd0, n_grant});
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            conflict_cnt_q <= '0;
        end else if (conflict && (conflict_cnt_q != 32'hFFFF_FFFF)) begin
            conflict_cnt_q <= conflict_cnt_q + 32'd1;
        end
    end

    assign perf_conflict_cnt = conflict_cnt_q;
`endif

endmodule

// File: tb/tb_cdb_arbiter.sv
module tb_cdb_arbiter;

    localparam int NR = 6;
    localparam int TW = 5;
    localparam int XW = 32;

    logic              clock = 1'b0;
    logic              reset;
    logic              squash;
    logic [NR-1:0]     req_valid;
    logic [NR*TW-1:0]  req_rob_idx;
    logic [NR*XW-1:0]  req_value;
    logic [NR-1:0]     req_ready;
    logic [1:0]        cdb_valid;
    logic [2*TW-1:0]   cdb_rob_idx;
    logic [2*XW-1:0]   cdb_value;
`ifdef CDB_ARB_PERF_EN
    logic [31:0]       perf_conflict_cnt;
`endif

    int total = 0;
    int bad   = 0;

    cdb_arbiter dut (
        .clock       (clock),
        .reset       (reset),
        .squash      (squash),
        .req_valid   (req_valid),
        .req_rob_idx (req_rob_idx),
        .req_value   (req_value),
        .req_ready   (req_ready),
        .cdb_valid   (cdb_valid),
        .cdb_rob_idx (cdb_rob_idx),
        .cdb_value   (cdb_value)
`ifdef CDB_ARB_PERF_EN
        ,
        .perf_conflict_cnt (perf_conflict_cnt)
`endif
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Advance one clock; inputs are driven and outputs sampled 1ns after the edge.
    task automatic step();
        @(posedge clock);
        #1;
    endtask

    // Lane checks: tag and value of lane l.
    task automatic check_lane(input string tag, input int l, input logic [4:0] t,
                              input logic [31:0] v);
        check({tag, "_tag"}, 64'(cdb_rob_idx[l*TW +: TW]), 64'(t));
        check({tag, "_val"}, 64'(cdb_value[l*XW +: XW]), 64'(v));
    endtask

    initial begin
        reset     = 1'b0;
        squash    = 1'b0;
        req_valid = 6'b111111;
        // Requester i: tag 10+i, value A000_0000+i.
        for (int i = 0; i < NR; i++) begin
            req_rob_idx[i*TW +: TW] = 5'(10 + i);
            req_value[i*XW +: XW]   = 32'hA000_0000 + 32'(i);
        end

        // Reset held two cycles with every requester valid.
        #1;
        check("rst_ready", 64'(req_ready), 64'h0);
        step();
        step();
        check("rst_ready2", 64'(req_ready), 64'h0);
        check("rst_cdb_valid", 64'(cdb_valid), 64'h0);
        check("rst_cdb_tag", 64'(cdb_rob_idx), 64'h0);
        check("rst_cdb_val", 64'(cdb_value), 64'h0);
        squash = 1'b1;
        #1;
        check("rst_squash_ready", 64'(req_ready), 64'h0);

        // Single requester 2.
        reset     = 1'b1;
        squash    = 1'b0;
        req_valid = 6'b000100;
        req_rob_idx[2*TW +: TW] = 5'd9;
        req_value[2*XW +: XW]   = 32'hDEAD_BEEF;
        #1;
        check("single_ready", 64'(req_ready), 64'b000100);
        step();
        req_valid = 6'b000000;
        req_rob_idx[2*TW +: TW] = 5'd12;
        req_value[2*XW +: XW]   = 32'hA000_0002;
        check("single_cdb_valid", 64'(cdb_valid), 64'b01);
        check_lane("single_l0", 0, 5'd9, 32'hDEAD_BEEF);
        #1;
        check("idle_ready", 64'(req_ready), 64'h0);

        // rr_ptr should be 3: all-valid grants {3,4}.
        req_valid = 6'b111111;
        #1;
        check("ptr3_ready", 64'(req_ready), 64'b011000);
        step();
        check("ptr3_cdb_valid", 64'(cdb_valid), 64'b11);
        check_lane("ptr3_l0", 0, 5'd13, 32'hA000_0003);
        check_lane("ptr3_l1", 1, 5'd14, 32'hA000_0004);

        // Re-reset to bring rr_ptr back to 0, then full load for 3 cycles.
        reset = 1'b0;
        step();
        check("rerst_cdb_valid", 64'(cdb_valid), 64'h0);
        reset = 1'b1;
        #1;
        check("full0_ready", 64'(req_ready), 64'b000011);
        step();
        check("full0_cdb_valid", 64'(cdb_valid), 64'b11);
        check_lane("full0_l0", 0, 5'd10, 32'hA000_0000);
        check_lane("full0_l1", 1, 5'd11, 32'hA000_0001);
        #1;
        check("full1_ready", 64'(req_ready), 64'b001100);
        step();
        check_lane("full1_l0", 0, 5'd12, 32'hA000_0002);
        check_lane("full1_l1", 1, 5'd13, 32'hA000_0003);
        #1;
        check("full2_ready", 64'(req_ready), 64'b110000);
        step();
        check_lane("full2_l0", 0, 5'd14, 32'hA000_0004);
        check_lane("full2_l1", 1, 5'd15, 32'hA000_0005);
        // Wrapped back to 0.
        req_valid = 6'b000001;
        #1;
        check("wrap0_ready", 64'(req_ready), 64'b000001);
        step();
        check("wrap0_cdb_valid", 64'(cdb_valid), 64'b01);

        // rr_ptr now 1; grant req4 alone to reach rr_ptr=5.
        req_valid = 6'b010000;
        #1;
        check("req4_ready", 64'(req_ready), 64'b010000);
        step();
        check_lane("req4_l0", 0, 5'd14, 32'hA000_0004);

        // Wrap selection: rr_ptr=5, valid {5,0} -> lane0=req5, lane1=req0.
        req_valid = 6'b100001;
        #1;
        check("wrap_ready", 64'(req_ready), 64'b100001);
        step();
        check("wrap_cdb_valid", 64'(cdb_valid), 64'b11);
        check_lane("wrap_l0", 0, 5'd15, 32'hA000_0005);
        check_lane("wrap_l1", 1, 5'd10, 32'hA000_0000);

        // Squash with rr_ptr=1: previous results remain visible this cycle.
        req_valid = 6'b000011;
        squash    = 1'b1;
        #1;
        check("sq_ready", 64'(req_ready), 64'h0);
        check("sq_cdb_visible", 64'(cdb_valid), 64'b11);
        step();
        check("sq_cdb_valid", 64'(cdb_valid), 64'b00);
        squash = 1'b0;
        #1;
        // rr_ptr held at 1: req1 first, then req0.
        check("post_sq_ready", 64'(req_ready), 64'b000011);
        step();
        check("post_sq_cdb_valid", 64'(cdb_valid), 64'b11);
        check_lane("post_sq_l0", 0, 5'd11, 32'hA000_0001);
        check_lane("post_sq_l1", 1, 5'd10, 32'hA000_0000);
        req_valid = 6'b000000;
        step();
        check("drain_cdb_valid", 64'(cdb_valid), 64'b00);
        // Idle lanes hold the last tag.
        check_lane("hold_l0", 0, 5'd11, 32'hA000_0001);

`ifdef CDB_ARB_PERF_EN
        reset = 1'b0;
        step();
        check("perf_rst", 64'(perf_conflict_cnt), 64'h0);
        reset     = 1'b1;
        req_valid = 6'b000111;
        repeat (4) step();
        req_valid = 6'b000000;
        check("perf_cnt4", 64'(perf_conflict_cnt), 64'd4);
        req_valid = 6'b000111;
        squash    = 1'b1;
        step();
        squash    = 1'b0;
        req_valid = 6'b000000;
        check("perf_sq_excl", 64'(perf_conflict_cnt), 64'd4);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Global time limit.
    initial begin
        #100000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
